// File: rtl/systolic_array_sequencer.sv
// Control sequencer for an N x N output-stationary systolic array: clears the PEs,
// skews operand/weight injection across rows and columns, drains, then pulses done.
module systolic_array_sequencer #(
    parameter int ARRAY_SIZE = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [K_WIDTH-1:0]            k_len_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          accumulate_en_o,
    output logic [ARRAY_SIZE-1:0]         row_valid_o,
    output logic [ARRAY_SIZE*K_WIDTH-1:0] row_addr_o,
    output logic [ARRAY_SIZE-1:0]         col_valid_o,
    output logic [ARRAY_SIZE*K_WIDTH-1:0] col_addr_o
);

    localparam int N  = ARRAY_SIZE;
    localparam int CW = K_WIDTH + 1;
    localparam int EW = K_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [K_WIDTH-1:0]     k_q, k_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   acc_q, acc_d;
    logic [N-1:0]           valid_q, valid_d;
    logic [N*K_WIDTH-1:0]   addr_q, addr_d;
    logic [EW-1:0]          f_ext;
    logic                   feed_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= 1'b0;
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs are derived from the next state so every output is a flop that
    // reflects the state the sequencer is entering on this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        feed_last = (EW'(cnt_q) == EW'(k_q) + EW'(N - 2));

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    if (k_len_i != '0) begin
                        k_d     = k_len_i;
                        state_d = CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = abort_i ? IDLE : FEED;
            end
            FEED: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (feed_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        acc_d   = (state_d == FEED) || (state_d == DRAIN);
        valid_d = '0;
        addr_d  = '0;
        f_ext   = EW'(cnt_d);

        // Row r and column r see the same skewed window, lagging by r cycles.
        if (state_d == FEED) begin
            for (int r = 0; r < N; r++) begin
                if (f_ext >= EW'(r) && f_ext < EW'(r) + EW'(k_d)) begin
                    valid_d[r]                    = 1'b1;
                    addr_d[r*K_WIDTH +: K_WIDTH]  = K_WIDTH'(f_ext - EW'(r));
                end
            end
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign accumulate_en_o = acc_q;
    assign row_valid_o     = valid_q;
    assign row_addr_o      = addr_q;
    assign col_valid_o     = valid_q;
    assign col_addr_o      = addr_q;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench for systolic_array_sequencer: each launched tile pushes its
// expected per-cycle output trace, which is popped and compared after every edge.
module tb_systolic_array_sequencer;

    localparam int N  = 4;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   kLen;
    logic            abort;
    logic            busy, done, accEn;
    logic [N-1:0]    rowValid, colValid;
    logic [N*KW-1:0] rowAddr, colAddr;

    typedef struct {
        logic            busy;
        logic            done;
        logic            acc;
        logic [N-1:0]    rv;
        logic [N-1:0]    cv;
        logic [N*KW-1:0] ra;
        logic [N*KW-1:0] ca;
    } expT;

    expT sb[$];
    int  errors = 0;
    int  checks = 0;
    logic [N-1:0] rvTable [6];
    logic [KW-1:0] maxAddr0;

    systolic_array_sequencer #(.ARRAY_SIZE(N), .K_WIDTH(KW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .k_len_i         (kLen),
        .abort_i         (abort),
        .busy_o          (busy),
        .done_o          (done),
        .accumulate_en_o (accEn),
        .row_valid_o     (rowValid),
        .row_addr_o      (rowAddr),
        .col_valid_o     (colValid),
        .col_addr_o      (colAddr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [N*KW-1:0] obs, input logic [N*KW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic expT zeroExp();
        expT e;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.acc  = 1'b0;
        e.rv   = '0;
        e.cv   = '0;
        e.ra   = '0;
        e.ca   = '0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input expT e);
        cmp({tag, ".busy"}, busy, e.busy);
        cmp({tag, ".done"}, done, e.done);
        cmp({tag, ".acc"}, accEn, e.acc);
        cmp({tag, ".rowValid"}, rowValid, e.rv);
        cmp({tag, ".rowAddr"}, rowAddr, e.ra);
        cmp({tag, ".colValid"}, colValid, e.cv);
        cmp({tag, ".colAddr"}, colAddr, e.ca);
    endtask

    task automatic applyStimulus(input logic s, input logic [KW-1:0] k, input logic a);
        start = s;
        kLen  = k;
        abort = a;
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(zeroExp());
    endtask

    // Expected trace of one tile, starting with the state entered on the start edge.
    task automatic pushTile(input int k);
        expT e;
        if (k != 0) begin
            e = zeroExp();
            e.busy = 1'b1;
            sb.push_back(e);
            for (int f = 0; f <= k + N - 2; f++) begin
                e = zeroExp();
                e.busy = 1'b1;
                e.acc  = 1'b1;
                for (int r = 0; r < N; r++) begin
                    if (f >= r && f < r + k) begin
                        e.rv[r]          = 1'b1;
                        e.cv[r]          = 1'b1;
                        e.ra[r*KW +: KW] = KW'(f - r);
                        e.ca[r*KW +: KW] = KW'(f - r);
                    end
                end
                sb.push_back(e);
            end
            for (int d = 0; d < N; d++) begin
                e = zeroExp();
                e.busy = 1'b1;
                e.acc  = 1'b1;
                sb.push_back(e);
            end
        end
        e = zeroExp();
        e.busy = 1'b1;
        e.done = 1'b1;
        sb.push_back(e);
    endtask

    task automatic popCheck(input string tag);
        expT e;
        step();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s.scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput(tag, e);
        end
    endtask

    task automatic runExpected(input string tag);
        while (sb.size() > 0) popCheck(tag);
    endtask

    initial begin
        rvTable[0] = 4'b0001;
        rvTable[1] = 4'b0011;
        rvTable[2] = 4'b0111;
        rvTable[3] = 4'b1110;
        rvTable[4] = 4'b1100;
        rvTable[5] = 4'b1000;

        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1 checkOutput("reset", zeroExp());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        kLen  = 8'd5;
        pushIdle(3);
        runExpected("postReset");

        // k=3 nominal tile, with the row/column valid skew checked against fixed patterns
        applyStimulus(1'b1, 8'd3, 1'b0);
        pushTile(3);
        popCheck("k3.clear");
        start = 1'b0;
        for (int f = 0; f < 6; f++) begin
            popCheck("k3.feed");
            cmp("k3.rowTable", rowValid, rvTable[f]);
            cmp("k3.colTable", colValid, rvTable[f]);
        end
        runExpected("k3.tail");
        pushIdle(1);
        runExpected("k3.idle");

        // k=0 goes straight to DONE; abort in IDLE and DONE is ignored
        applyStimulus(1'b1, 8'd0, 1'b1);
        pushTile(0);
        popCheck("k0");
        start = 1'b0;
        pushIdle(2);
        runExpected("k0.idle");
        abort = 1'b0;

        // start and k_len changes while busy have no effect
        applyStimulus(1'b1, 8'd2, 1'b0);
        pushTile(2);
        popCheck("k2.clear");
        start = 1'b0;
        popCheck("k2.feed");
        popCheck("k2.feed");
        applyStimulus(1'b1, 8'd7, 1'b0);
        for (int i = 0; i < 3; i++) popCheck("k2.busyStart");
        applyStimulus(1'b0, 8'd2, 1'b0);
        runExpected("k2.tail");
        pushIdle(1);
        runExpected("k2.idle");

        // abort at f=2, then a k=1 tile completes normally
        applyStimulus(1'b1, 8'd3, 1'b0);
        pushTile(3);
        popCheck("abort.clear");
        start = 1'b0;
        for (int i = 0; i < 3; i++) popCheck("abort.feed");
        abort = 1'b1;
        sb.delete();
        pushIdle(1);
        popCheck("abort.idle");
        abort = 1'b0;
        pushIdle(3);
        runExpected("abort.noDone");
        applyStimulus(1'b1, 8'd1, 1'b0);
        pushTile(1);
        popCheck("k1.clear");
        start = 1'b0;
        runExpected("k1.tail");
        pushIdle(1);
        runExpected("k1.idle");

        // back-to-back tiles with start held high: one IDLE cycle between them
        applyStimulus(1'b1, 8'd1, 1'b0);
        pushTile(1);
        pushIdle(1);
        pushTile(1);
        for (int i = 0; i < 12; i++) popCheck("b2b.first");
        start = 1'b0;
        runExpected("b2b.second");
        pushIdle(1);
        runExpected("b2b.idle");

        // asynchronous reset in the middle of FEED
        applyStimulus(1'b1, 8'd5, 1'b0);
        pushTile(5);
        popCheck("rst.clear");
        start = 1'b0;
        popCheck("rst.feed");
        popCheck("rst.feed");
        #2 rst_n = 1'b0;
        #1 checkOutput("rst.async", zeroExp());
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pushIdle(2);
        runExpected("rst.idle");

        // longest tile: counters must not wrap
        applyStimulus(1'b1, 8'd255, 1'b0);
        pushTile(255);
        popCheck("k255.clear");
        start = 1'b0;
        maxAddr0 = '0;
        while (sb.size() > 0) begin
            popCheck("k255");
            if (rowAddr[KW-1:0] > maxAddr0) maxAddr0 = rowAddr[KW-1:0];
        end
        cmp("k255.maxAddr0", maxAddr0, 8'd254);
        pushIdle(1);
        runExpected("k255.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_sequencer.md
SYSTOLIC_ARRAY_SEQUENCER -- requirements
Module: systolic_array_sequencer

Interface
REQ-001 Parameter ARRAY_SIZE, default 4: the systolic array is N x N with N = ARRAY_SIZE, N >= 2.
REQ-002 Parameter K_WIDTH, default 8: width of the accumulation length and of each operand read address.
REQ-003 clk  input  1  clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 start  input  1  request to run one tile computation; sampled only in IDLE.
REQ-006 k_len  input  K_WIDTH  number of accumulation steps (inner dimension); sampled with start.
REQ-007 abort  input  1  synchronous cancel of the current tile.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the tile completes.
REQ-010 accumulate_en  output  1  broadcast accumulate enable to all PEs.
REQ-011 row_valid  output  N  per-row data_valid injected at the west edge of the array.
REQ-012 row_addr  output  N*K_WIDTH  per-row operand read address; row r occupies bits [r*K_WIDTH +: K_WIDTH].
REQ-013 col_valid  output  N  per-column weight_valid injected at the north edge of the array.
REQ-014 col_addr  output  N*K_WIDTH  per-column weight read address; column c occupies bits [c*K_WIDTH +: K_WIDTH].

Function
REQ-015 The FSM SHALL have five states, IDLE, CLEAR, FEED, DRAIN and DONE, and every output SHALL be driven from a register.
REQ-016 IDLE: on start=1 with k_len!=0, the block SHALL latch k_len and go to CLEAR; if start=1 with k_len==0, it SHALL go directly to DONE with no valids asserted.
REQ-017 CLEAR SHALL last exactly 1 cycle with accumulate_en=0, giving the PEs a guaranteed 0->1 edge on accumulate_en so they clear.
REQ-018 FEED SHALL last k_len+N-1 cycles, with the feed counter f running from 0 to k_len+N-2; accumulate_en=1.
REQ-019 During FEED, row_valid[r] SHALL be 1 iff r <= f < r+k_len, and row_addr[r] SHALL be f-r when valid, else 0.
REQ-020 During FEED, col_valid[c] SHALL be 1 iff c <= f < c+k_len, and col_addr[c] SHALL be f-c when valid, else 0.
REQ-021 DRAIN SHALL last N cycles with accumulate_en=1 and all valids at 0, letting the last MAC reach PE(N-1,N-1) and register.
REQ-022 DONE SHALL last 1 cycle with done=1, accumulate_en=0 and busy=1, then return to IDLE.
REQ-023 accumulate_en SHALL be 0 in IDLE, CLEAR and DONE.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued; k_len changes while busy SHALL have no effect.
REQ-025 abort=1 in CLEAR, FEED or DRAIN SHALL force IDLE on the next edge, clear all valids, addresses and accumulate_en, and SHALL NOT produce done.
REQ-026 abort in IDLE or DONE SHALL be ignored, so the done pulse of a completed tile is not suppressed.
REQ-027 When k_len = 2^K_WIDTH-1, counters SHALL NOT wrap; the internal feed counter SHALL be at least K_WIDTH+1 bits wide.
REQ-028 Back-to-back operation: start held high SHALL launch the next tile from the IDLE cycle that follows DONE, giving a minimum gap of 1 idle cycle between tiles.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, accumulate_en=0, all valids 0, all addresses 0 and counters 0, including in the middle of a tile.
REQ-030 After rst_n deasserts, no output SHALL change until start is sampled.

Verification
REQ-031 N=4, k_len=3, start pulse -> CLEAR for 1 cycle, FEED for 6 cycles, DRAIN for 4 cycles; done high for exactly 1 cycle, set by the 11th edge after the start-sampling edge.
REQ-032 Same run -> row_valid sequence over f=0..5 is 0001,0011,0111,1110,1100,1000; row_addr[3] is 0,1,2 at f=3,4,5; col_valid matches row_valid.
REQ-033 k_len=0 -> done on the next cycle; row_valid, col_valid and accumulate_en stay 0 throughout.
REQ-034 abort at f=2 -> IDLE on the next edge, all outputs 0, no done; a following start with k_len=1 completes normally (done set by the 9th edge after its start edge).
REQ-035 rst_n pulsed low mid-FEED -> outputs go to 0 immediately, without waiting for a clock edge; start held high during DONE -> second tile's CLEAR follows exactly 1 IDLE cycle.
REQ-036 k_len=255, K_WIDTH=8 -> FEED lasts 258 cycles, row_addr[0] reaches 254, and no counter wrap occurs.
